systolic_seq: RTL and testbench

Tile sequencer for the input-skewing feed and LEN×LEN systolic array. One `start` launches one tile:
- clear the PE accumulators;
- stream `k_len` operand vectors from the operand buffer into the skew feed;
- hold the feed enabled while zeros flush the pipeline;
- pulse `done` once the array results are final.

The block sits between the host-side control registers and the operand buffer / feed / PE array, and drives only control signals.

---
 rtl/systolic_seq.sv | 177 +++++++++++++++++
 tb/tb_systolic_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq.sv
// systolic_seq: tile sequencer for the skew feed and LEN x LEN systolic array.
// One accepted start runs CLEAR -> STREAM (K reads) -> FLUSH (2*LEN-1 cycles)
// -> DONE. It drives only control strobes, the operand buffer read address and
// the optional performance counters.
// Optional feature: define SEQ_PERF_CNT_EN to build the busy-cycle and
// completed-tile counters; otherwise perf_cycles/perf_tiles are tied to 0.
module systolic_seq #(
    parameter int LEN   = 2,
    parameter int DEP   = 2,
    parameter int K_MAX = 256,
    parameter int AW    = $clog2(K_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   k_len,
    output logic          busy,
    output logic          done,
    output logic          acc_clr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          feed_en,
    output logic          feed_zero,
    output logic [31:0]   perf_cycles,
    output logic [31:0]   perf_tiles
);

    // Flush length: zeros must travel through the skew and the full array.
    localparam int F  = 2 * LEN - 1;
    localparam int FW = (F > 1) ? $clog2(F) : 1;
    localparam logic [AW:0]   K_MAX_V  = (AW + 1)'(K_MAX);
    localparam logic [FW-1:0] F_LAST_V = FW'(F - 1);

    // Reject meaningless geometry at elaboration time.
    if (LEN < 1 || DEP < 1 || K_MAX < 1) begin : g_param_check
        $error("systolic_seq: LEN, DEP and K_MAX must all be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   k_q, k_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          feed_en_q, feed_en_d;
    logic          feed_zero_q, feed_zero_d;
    logic          stream_last;

    // Last stream cycle: the current address is the final operand vector.
    assign stream_last = ({1'b0, rd_addr_q} == (k_q - 1'b1));

    // State register and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            rd_addr_q   <= '0;
            flush_cnt_q <= '0;
            feed_en_q   <= 1'b0;
            feed_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rd_addr_q   <= rd_addr_d;
            flush_cnt_q <= flush_cnt_d;
            feed_en_q   <= feed_en_d;
            feed_zero_q <= feed_zero_d;
        end
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rd_addr_d   = rd_addr_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (k_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                        k_d     = (k_len > K_MAX_V) ? K_MAX_V : k_len;
                    end
                end
            end
            S_CLEAR: begin
                state_d   = S_STREAM;
                rd_addr_d = '0;
            end
            S_STREAM: begin
                if (stream_last) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == F_LAST_V) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            rd_addr_d = rd_addr_q;
        end
    end

    // Feed enables lag the state by one cycle to line up with read latency.
    always_comb begin
        feed_en_d   = !abort && (state_q == S_STREAM || state_q == S_FLUSH);
        feed_zero_d = !abort && (state_q == S_FLUSH);
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign acc_clr   = (state_q == S_CLEAR);
    assign rd_en     = (state_q == S_STREAM);
    assign rd_addr   = rd_addr_q;
    assign feed_en   = feed_en_q;
    assign feed_zero = feed_zero_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] busy_cnt_q, busy_cnt_d;
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_tiles_q, perf_tiles_d;

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q    <= '0;
            perf_cycles_q <= '0;
            perf_tiles_q  <= '0;
        end else begin
            busy_cnt_q    <= busy_cnt_d;
            perf_cycles_q <= perf_cycles_d;
            perf_tiles_q  <= perf_tiles_d;
        end
    end

    // Busy cycles restart from zero in IDLE; DONE publishes total incl. itself.
    always_comb begin
        busy_cnt_d    = (state_q == S_IDLE) ? 32'd0 : busy_cnt_q + 32'd1;
        perf_cycles_d = perf_cycles_q;
        perf_tiles_d  = perf_tiles_q;
        if (state_q == S_DONE) begin
            perf_cycles_d = busy_cnt_q + 32'd1;
            perf_tiles_d  = perf_tiles_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_tiles  = perf_tiles_q;
`else
    assign perf_cycles = 32'd0;
    assign perf_tiles  = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Testbench for systolic_seq: directed and randomized tiles checked cycle by
// cycle against a timeline model derived from the tile schedule.
module tb_systolic_seq;

    localparam int LEN   = 2;
    localparam int DEP   = 2;
    localparam int K_MAX = 256;
    localparam int AW    = $clog2(K_MAX);
    localparam int F     = 2 * LEN - 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW:0]   k_len;
    logic          busy;
    logic          done;
    logic          acc_clr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          feed_en;
    logic          feed_zero;
    logic [31:0]   perf_cycles;
    logic [31:0]   perf_tiles;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int last_addr  = 0;
    int exp_tiles  = 0;
    int exp_cycles = 0;

    systolic_seq #(
        .LEN   (LEN),
        .DEP   (DEP),
        .K_MAX (K_MAX),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .k_len       (k_len),
        .busy        (busy),
        .done        (done),
        .acc_clr     (acc_clr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .feed_en     (feed_en),
        .feed_zero   (feed_zero),
        .perf_cycles (perf_cycles),
        .perf_tiles  (perf_tiles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_perf_tiles();
`ifdef SEQ_PERF_CNT_EN
        return 32'(exp_tiles);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_perf_cycles();
`ifdef SEQ_PERF_CNT_EN
        return 32'(exp_cycles);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_acc_clr"}, 32'(acc_clr), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_feed_en"}, 32'(feed_en), 0);
        chk({tag, "_feed_zero"}, 32'(feed_zero), 0);
        chk({tag, "_perf_cycles"}, perf_cycles, 0);
        chk({tag, "_perf_tiles"}, perf_tiles, 0);
    endtask

    // Launch one tile at the current cycle (cycle 0) and follow its timeline.
    // abort_at/reset_at = 0 means no abort / no reset during the tile.
    task automatic run_tile(input int klen, input int abort_at, input int reset_at, input bit hold);
        int k;
        int dc;
        bit e_clr, e_rd, e_fe, e_fz, e_done;
        k  = (klen > K_MAX) ? K_MAX : klen;
        dc = (k == 0) ? 1 : k + 2 + F;
        $display("tile k_len=%0d K=%0d abort_at=%0d reset_at=%0d hold=%0d", klen, k, abort_at, reset_at, hold);
        start = 1'b1;
        k_len = (AW + 1)'(klen);
        abort = 1'b0;
        for (int c = 1; c <= dc; c++) begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            if (abort_at != 0 && c == abort_at + 1) begin
                abort = 1'b0;
                start = 1'b0;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_feed_en", 32'(feed_en), 0);
                chk("abort_rd_en", 32'(rd_en), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_rd_addr", 32'(rd_addr), 32'(last_addr));
                chk("abort_perf_tiles", perf_tiles, exp_perf_tiles());
                return;
            end
            e_clr  = (k > 0) && (c == 1);
            e_rd   = (k > 0) && (c >= 2) && (c <= k + 1);
            e_fe   = (k > 0) && (c >= 3) && (c <= k + 2 + F);
            e_fz   = (k > 0) && (c >= k + 3) && (c <= k + 2 + F);
            e_done = (c == dc);
            if (e_rd) last_addr = c - 2;
            chk("busy", 32'(busy), 1);
            chk("acc_clr", 32'(acc_clr), 32'(e_clr));
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            chk("rd_addr", 32'(rd_addr), 32'(last_addr));
            chk("feed_en", 32'(feed_en), 32'(e_fe));
            chk("feed_zero", 32'(feed_zero), 32'(e_fz));
            chk("done", 32'(done), 32'(e_done));
            if (c == reset_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                @(posedge clk);
                #1;
                rst_n     = 1'b1;
                last_addr = 0;
                exp_tiles = 0;
                exp_cycles = 0;
                return;
            end
            if (c == abort_at) abort = 1'b1;
        end
        exp_tiles  = exp_tiles + 1;
        exp_cycles = dc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_feed_en", 32'(feed_en), 0);
        chk("perf_cycles", perf_cycles, exp_perf_cycles());
        chk("perf_tiles", perf_tiles, exp_perf_tiles());
    endtask

    initial begin
        int kr;
        int ab;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_busy", 32'(busy), 0);

        // Directed tiles from the schedule.
        run_tile(4, 0, 0, 1'b0);
        run_tile(0, 0, 0, 1'b0);
        run_tile(300, 0, 0, 1'b0);
        run_tile(4, 4, 0, 1'b0);
        run_tile(5, 0, 0, 1'b1);

        // start together with abort in IDLE launches nothing.
        $display("idle start+abort");
        start = 1'b1;
        abort = 1'b1;
        k_len = (AW + 1)'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        chk("sa_acc_clr", 32'(acc_clr), 0);
        chk("sa_done", 32'(done), 0);
        @(posedge clk);
        #1;
        chk("sa_busy2", 32'(busy), 0);

        // Reset during FLUSH (cycle 7 of a K=4 tile), then a fresh K=1 tile.
        run_tile(4, 0, 7, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_idle_busy", 32'(busy), 0);
        run_tile(1, 0, 0, 1'b0);

        // Randomized tiles, some aborted at a random point.
        for (int i = 0; i < 12; i++) begin
            kr = int'($urandom_range(0, 20));
            ab = 0;
            if (kr > 0 && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, kr + 1 + F));
            run_tile(kr, ab, 0, 1'(i % 3 == 0));
            repeat (int'($urandom_range(0, 2))) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
